sg_engine: RTL and testbench
============================

# sg_engine

Parametrised scatter/gather engine that walks a stream of element indices, computes `base + (index << ELEM_SHIFT)` for each one, and issues one memory request per element. Gather mode returns the read data in index order on an output stream. Scatter mode writes a paired data stream to the computed addresses. It sits between the command/descriptor logic and the on-chip memory port, replacing single-address generation with a full multi-element, handshaked transfer.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, element data width
- `IDX_W`, 32, index width
- `LEN_W`, 8, element-count width
- `ELEM_SHIFT`, 2, log2 of element size in bytes
- `IDX_LIMIT`, 1024, first out-of-range index (used only with bounds check)

Ports:
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `cmd_valid` / `cmd_ready` in/out 1: command handshake
- `cmd_mode` in 1: 0 = gather, 1 = scatter
- `cmd_base` in ADDR_W: base address
- `cmd_len` in LEN_W: element count
- `idx_valid` / `idx_ready` in/out 1: index stream handshake
- `idx_data` in IDX_W: element index
- `wr_valid` / `wr_ready` in/out 1: scatter write-data handshake
- `wr_data` in DATA_W: scatter write data
- `mem_req_valid` / `mem_req_ready` out/in 1: memory request handshake
- `mem_req_we` out 1: 1 = write
- `mem_req_addr` out ADDR_W: request address
- `mem_req_wdata` out DATA_W: write data
- `mem_rsp_valid` in 1: read-response strobe
- `mem_rsp_rdata` in DATA_W: read data
- `out_valid` / `out_ready` out/in 1: gather result handshake
- `out_data` out DATA_W: gathered element
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at end of command
- `oob_err` out 1: sticky out-of-bounds flag

## Operation
- States: IDLE, FETCH, REQ, RSP, OUT, DONE.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`, latch mode, base and len, and clear `oob_err`.
  - `cmd_len`=0 → DONE.
  - Otherwise → FETCH with element counter = 0.
- **FETCH, gather:** `idx_ready`=1. On `idx_valid`, register the address → REQ.
- **FETCH, scatter:** joint handshake.
  - `idx_ready` = `wr_ready` = `idx_valid && wr_valid`.
  - Both streams are consumed in the same cycle; address and `wr_data` are registered → REQ.
- **REQ:** `mem_req_valid`=1. Address, `we` and `wdata` stay stable until `mem_req_ready`.
  - On handshake, scatter increments the count → FETCH, or → DONE if it was the last element.
  - On handshake, gather → RSP.
- **RSP:** wait for `mem_rsp_valid`, capture `mem_rsp_rdata` → OUT. `mem_rsp_valid` in any other state is ignored.
- **OUT:** `out_valid`=1, `out_data` held until `out_ready`. On handshake, increment the count → FETCH, or → DONE if it was the last element.
- **DONE:** `done`=1 for one cycle → IDLE.
- **Address arithmetic:**
  - Index is zero-extended and shifted left by `ELEM_SHIFT`.
  - The sum is truncated to ADDR_W, so addresses wrap modulo 2^ADDR_W with no error.
- **Ordering:** one outstanding request at most, so results come out in index order.

## Timing
- Reset values: `cmd_ready`=0 while `rst`=1, then 1 in IDLE. All other outputs are 0 (`busy`, `done`, `oob_err`, valids, readys, `mem_req_*`, `out_data`). State is IDLE.
- `rst` mid-command aborts immediately.
  - No `done` pulse.
  - Pending request dropped.
  - A late `mem_rsp_valid` after reset is ignored.
- Command accepted in cycle T → `busy`=1 and FETCH at T+1.
- Index accepted in cycle F → `mem_req_valid`=1 at F+1 (registered address).
- Response in cycle R → `out_valid`=1 at R+1.
- Last handshake in cycle L → `done`=1 at L+1 → IDLE and `cmd_ready`=1 at L+2.
- Gather best case, with `mem_req_ready` always high and the response one cycle after the request: 4 cycles per element.
- Scatter best case: 2 cycles per element.
- `cmd_len`=0: `done` at T+1, no memory traffic.
- `cmd_valid` while busy is not accepted because `cmd_ready`=0.

## Configuration
- `SG_BOUNDS_CHECK_EN` defined: in FETCH, an index ≥ `IDX_LIMIT` issues no memory request and sets `oob_err` (sticky until the next command accept).
  - Gather: OUT presents `out_data`=0 for that element, so position is preserved.
  - Scatter: the write data is consumed and discarded, and the count advances.
- `SG_BOUNDS_CHECK_EN` undefined: no comparison is made, every index generates a request, and `oob_err` is tied to 0.

## Test plan
- Gather, base 0x1000, len 3, indices 0,5,3, `ELEM_SHIFT`=2, memory returns addr^0xFFFF → requests at 0x1000, 0x1014, 0x100C; `out_data` = 0xEFFF, 0xEFEB, 0xEFF3 in order; `done` once.
- Scatter, base 0x2000, len 2, indices 1,2, data 0xAA,0xBB → writes (0x2004,0xAA), (0x2008,0xBB) with `we`=1. If `wr_valid` is delayed 3 cycles, there is no index consume before data arrives.
- Backpressure: `mem_req_ready` low 5 cycles and `out_ready` low 4 cycles → `mem_req_addr` and `out_data` stay stable; no element lost or duplicated.
- `cmd_len`=0 → `done` 1 cycle after accept, zero requests. Base 0xFFFFFFFC with index 1 → address 0x00000000.
- `rst` asserted in RSP → next cycle all outputs 0 and state IDLE; a following 1-element gather completes normally.
- With `SG_BOUNDS_CHECK_EN` and `IDX_LIMIT`=1024: indices 2,1024,3 → 2 requests, middle `out_data`=0, `oob_err`=1 until the next command.

Source files
------------

// File: rtl/sg_engine.sv
// Scatter/gather engine: walks an index stream, issues one memory request per element
// at base + (index << ELEM_SHIFT). Optional bounds check enabled by SG_BOUNDS_CHECK_EN.
module sg_engine #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IDX_W      = 32,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ELEM_SHIFT = 2,
  parameter int unsigned IDX_LIMIT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              idx_valid,
  output logic              idx_ready,
  input  logic [IDX_W-1:0]  idx_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              oob_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_REQ, S_RSP, S_OUT, S_DONE} state_t;

`ifdef SG_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t              r_state, w_next;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_oob;

  logic                w_cmd_fire;
  logic                w_idx_fire;
  logic                w_last;
  logic                w_oob;
  logic [ADDR_W-1:0]   w_addr;

  // Zero-extend (or truncate) the index first; the sum then wraps modulo 2^ADDR_W.
  assign w_addr = r_base + (ADDR_W'(idx_data) << ELEM_SHIFT);
  assign w_last = (r_cnt == r_len - LEN_W'(1));
  assign w_oob  = BOUNDS_EN && ({1'b0, idx_data} >= (IDX_W+1)'(IDX_LIMIT));

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    idx_ready  = 1'b0;
    wr_ready   = 1'b0;
    w_cmd_fire = 1'b0;
    w_idx_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready  = !rst;
        w_cmd_fire = cmd_valid && !rst;
        if (w_cmd_fire) w_next = (cmd_len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (!r_mode) begin
          idx_ready  = 1'b1;
          w_idx_fire = idx_valid;
        end else begin
          // Scatter consumes index and data together so neither stream runs ahead.
          idx_ready  = idx_valid && wr_valid;
          wr_ready   = idx_valid && wr_valid;
          w_idx_fire = idx_valid && wr_valid;
        end
        if (w_idx_fire) begin
          if (!w_oob)      w_next = S_REQ;
          else if (!r_mode) w_next = S_OUT;
          else             w_next = w_last ? S_DONE : S_FETCH;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (r_mode) w_next = w_last ? S_DONE : S_FETCH;
          else        w_next = S_RSP;
        end
      end
      S_RSP:   if (mem_rsp_valid) w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= 1'b0;
      r_base  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_oob   <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_mode <= cmd_mode;
        r_base <= cmd_base;
        r_len  <= cmd_len;
        r_cnt  <= '0;
        r_oob  <= 1'b0;
      end
      if (w_idx_fire) begin
        if (!w_oob) begin
          r_addr  <= w_addr;
          r_we    <= r_mode;
          r_wdata <= r_mode ? wr_data : '0;
        end else begin
          // Out-of-range element: gather emits zero data, scatter drops the data.
          r_oob <= 1'b1;
          if (!r_mode) r_rdata <= '0;
          else         r_cnt   <= r_cnt + LEN_W'(1);
        end
      end
      if (r_state == S_REQ && mem_req_ready && r_mode) r_cnt <= r_cnt + LEN_W'(1);
      if (r_state == S_RSP && mem_rsp_valid) r_rdata <= mem_rsp_rdata;
      if (r_state == S_OUT && out_ready) r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign mem_req_valid = (r_state == S_REQ);
  assign out_valid     = (r_state == S_OUT);
  assign mem_req_addr  = r_addr;
  assign mem_req_we    = r_we;
  assign mem_req_wdata = r_wdata;
  assign out_data      = r_rdata;
  assign oob_err       = r_oob;

endmodule

// File: tb/tb_sg_engine.sv
// Scoreboard bench for sg_engine: a reference model queues expected memory requests and
// gather results; a monitor pops and compares on every handshake.
module tb_sg_engine;
  localparam int unsigned AW = 32, DW = 32, IW = 32, LW = 8, ES = 2, LIM = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_mode;
  logic [AW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;
  logic          idx_valid, idx_ready;
  logic [IW-1:0] idx_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          busy, done, oob_err;

  sg_engine #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW), .LEN_W(LW), .ELEM_SHIFT(ES),
              .IDX_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } req_t;
  req_t        exp_req[$];
  logic [31:0] exp_out[$];
  logic [31:0] qi[$];
  logic [31:0] qd[$];

  int checks = 0, failures = 0;
  int done_cnt = 0;
  bit fast = 0, rsp_hold = 0, scat_cmd = 0;
  int req_stall = 0, out_stall = 0;
  bit pend = 0;
  logic [31:0] pend_addr;
  int pend_dly;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Memory and sink: readies, plus a read responder returning addr ^ 0xFFFF.
  initial begin
    mem_req_ready = 0; out_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (req_stall > 0 && mem_req_valid) begin mem_req_ready = 0; req_stall--; end
      else mem_req_ready = fast || ($urandom_range(0, 3) != 0);
      if (out_stall > 0 && out_valid) begin out_ready = 0; out_stall--; end
      else out_ready = fast || ($urandom_range(0, 3) != 0);
      if (pend && !rsp_hold) begin
        if (pend_dly == 0) begin
          mem_rsp_valid = 1; mem_rsp_rdata = pend_addr ^ 32'hFFFF; pend = 0;
        end else begin
          pend_dly--; mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
        end
      end else if (pend) begin
        mem_rsp_valid = 0;
      end else begin
        // Stray strobes while no read is outstanding must be ignored.
        mem_rsp_valid = !fast && ($urandom_range(0, 7) == 0);
        mem_rsp_rdata = $urandom;
      end
    end
  end

  // Monitor: scoreboard pops and stability checks.
  initial begin
    bit          hreq, hout;
    logic [31:0] haddr, hwd, hout_d;
    req_t        r;
    hreq = 0; hout = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hreq = 0; hout = 0;
      end else begin
        if (hreq) chk(mem_req_valid && mem_req_addr == haddr && mem_req_wdata == hwd,
                      "req_stable", mem_req_addr, haddr);
        if (hout) chk(out_valid && out_data == hout_d, "out_stable", out_data, hout_d);
        if (mem_req_valid && mem_req_ready) begin
          if (!mem_req_we) begin
            pend = 1; pend_addr = mem_req_addr; pend_dly = fast ? 0 : $urandom_range(0, 3);
          end
          if (exp_req.size() == 0) chk(0, "unexpected_req", mem_req_addr, '0);
          else begin
            r = exp_req.pop_front();
            chk(mem_req_we == r.we, "req_we", 32'(mem_req_we), 32'(r.we));
            chk(mem_req_addr == r.addr, "req_addr", mem_req_addr, r.addr);
            if (r.we) chk(mem_req_wdata == r.wdata, "req_wdata", mem_req_wdata, r.wdata);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) chk(0, "unexpected_out", out_data, '0);
          else begin
            logic [31:0] e;
            e = exp_out.pop_front();
            chk(out_data == e, "out_data", out_data, e);
          end
        end
        if (scat_cmd && busy && (idx_ready || wr_ready))
          chk(idx_ready && wr_ready && idx_valid && wr_valid, "scatter_joint",
              {28'd0, idx_ready, wr_ready, idx_valid, wr_valid}, 32'hF);
        if (done) done_cnt++;
        hreq = mem_req_valid && !mem_req_ready; haddr = mem_req_addr; hwd = mem_req_wdata;
        hout = out_valid && !out_ready;         hout_d = out_data;
      end
    end
  end

  task automatic do_reset();
    rst = 1; cmd_valid = 0; idx_valid = 0; wr_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_req.delete(); exp_out.delete(); pend = 0;
  endtask

  task automatic feed_idx(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      int g; bit ok;
      g = (gap > 0) ? $urandom_range(0, gap) : 0;
      repeat (g) begin @(posedge clk); #1; end
      idx_valid = 1; idx_data = qi[i]; ok = 0;
      for (int t = 0; t < 300; t++) begin @(negedge clk); if (idx_ready) begin ok = 1; break; end end
      @(posedge clk); #1 idx_valid = 0; idx_data = $urandom;
      if (!ok) begin chk(0, "idx_accept_timeout", 32'(i), 32'(len)); break; end
    end
  endtask

  task automatic feed_wr(input int len, input int gap, input int wdelay);
    for (int i = 0; i < len; i++) begin
      int g; bit ok;
      g = ((gap > 0) ? $urandom_range(0, gap) : 0) + wdelay;
      repeat (g) begin @(posedge clk); #1; end
      wr_valid = 1; wr_data = qd[i]; ok = 0;
      for (int t = 0; t < 300; t++) begin @(negedge clk); if (wr_ready) begin ok = 1; break; end end
      @(posedge clk); #1 wr_valid = 0; wr_data = $urandom;
      if (!ok) begin chk(0, "wr_accept_timeout", 32'(i), 32'(len)); break; end
    end
  endtask

  task automatic run_cmd(input bit mode, input logic [31:0] base, input int len,
                         input int gap, input int wdelay);
    bit exp_oob, ok, seen;
    int acc, dcyc, d0;
    exp_oob = 0;
    for (int i = 0; i < len; i++) begin
      logic [31:0] a;
      bit oob;
      a = base + qi[i] * 32'd4;
`ifdef SG_BOUNDS_CHECK_EN
      oob = (qi[i] >= LIM);
`else
      oob = 0;
`endif
      if (oob) begin exp_oob = 1; if (!mode) exp_out.push_back('0); end
      else if (mode) exp_req.push_back('{1'b1, a, qd[i]});
      else begin exp_req.push_back('{1'b0, a, '0}); exp_out.push_back(a ^ 32'hFFFF); end
    end
    scat_cmd = mode; d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_mode = mode; cmd_base = base; cmd_len = LW'(len);
    ok = 0;
    for (int t = 0; t < 100; t++) begin @(negedge clk); if (cmd_ready) begin ok = 1; break; end end
    chk(ok, "cmd_accept", 32'(cmd_ready), 32'd1);
    acc = cyc;
    @(posedge clk); #1 cmd_valid = 0; cmd_base = $urandom; cmd_len = LW'($urandom);
    seen = 0; dcyc = 0;
    fork
      begin
        @(negedge clk);
        chk(busy == 1, "busy_after_accept", 32'(busy), 32'd1);
        chk(done == (len == 0), "done_at_accept_plus1", 32'(done), 32'(len == 0));
        if (done) begin seen = 1; dcyc = cyc; end
      end
      feed_idx(len, gap);
      if (mode) feed_wr(len, gap, wdelay);
    join
    if (!seen)
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        if (done) begin seen = 1; dcyc = cyc; break; end
      end
    chk(seen, "done_seen", 32'(seen), 32'd1);
    if (!seen) begin do_reset(); return; end
    if (fast) chk(dcyc - acc == (mode ? 2 : 4) * len + 1, "best_case_latency",
                  32'(dcyc - acc), 32'((mode ? 2 : 4) * len + 1));
    @(negedge clk);
    chk(!done && cmd_ready && !busy, "idle_after_done", {29'd0, done, cmd_ready, busy}, 32'd2);
    chk(done_cnt == d0 + 1, "done_pulses", 32'(done_cnt - d0), 32'd1);
    chk(exp_req.size() == 0 && exp_out.size() == 0, "all_elements_seen",
        32'(exp_req.size() + exp_out.size()), 32'd0);
    chk(oob_err == exp_oob, "oob_err", 32'(oob_err), 32'(exp_oob));
    exp_req.delete(); exp_out.delete();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({busy, done, oob_err, mem_req_valid, mem_req_we, idx_ready, wr_ready, out_valid} == 8'd0,
        nm, {24'd0, busy, done, oob_err, mem_req_valid, mem_req_we, idx_ready, wr_ready, out_valid}, '0);
    chk(mem_req_addr == '0 && mem_req_wdata == '0 && out_data == '0, {nm, "_data"},
        mem_req_addr | mem_req_wdata | out_data, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required<=%0d", cyc, 50000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1; cmd_valid = 0; cmd_mode = 0; cmd_base = '0; cmd_len = '0;
    idx_valid = 0; idx_data = '0; wr_valid = 0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(cmd_ready == 0, "cmd_ready_in_reset", 32'(cmd_ready), '0);
    chk_zero_outputs("reset_outputs");
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk(cmd_ready == 1, "cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed gather: 0,5,3 from 0x1000.
    fast = 1;
    qi = {32'd0, 32'd5, 32'd3};
    run_cmd(0, 32'h1000, 3, 0, 0);
    // Directed scatter at best-case rate.
    qi = {32'd1, 32'd2}; qd = {32'hAA, 32'hBB};
    run_cmd(1, 32'h2000, 2, 0, 0);
    qi = {32'd7, 32'd0, 32'd9, 32'd4};
    run_cmd(0, 32'h0000_3000, 4, 0, 0);
    qi = {32'd3, 32'd1, 32'd8, 32'd2}; qd = {32'h11, 32'h22, 32'h33, 32'h44};
    run_cmd(1, 32'h0000_4000, 4, 0, 0);
    // Empty command and address wrap.
    run_cmd(0, 32'h5000, 0, 0, 0);
    qi = {32'd1};
    run_cmd(0, 32'hFFFF_FFFC, 1, 0, 0);

    fast = 0;
    // Scatter data arriving late: index must not be consumed alone.
    qi = {32'd1, 32'd2}; qd = {32'hAA, 32'hBB};
    run_cmd(1, 32'h2000, 2, 0, 3);
    // Backpressure on both memory request and result sink.
    req_stall = 5; out_stall = 4;
    qi = {32'd6, 32'd2, 32'd9};
    run_cmd(0, 32'h6000, 3, 0, 0);
    req_stall = 0; out_stall = 0;
    // Out-of-range index in the middle (zero result only with bounds check built in).
    qi = {32'd2, 32'd1024, 32'd3};
    run_cmd(0, 32'h7000, 3, 1, 0);
    qi = {32'd2, 32'd2000, 32'd3}; qd = {32'h1, 32'h2, 32'h3};
    run_cmd(1, 32'h7000, 3, 1, 0);

    // Reset while waiting for a read response.
    rsp_hold = 1; scat_cmd = 0; d0 = done_cnt;
    exp_req.push_back('{1'b0, 32'h8008, '0});
    @(posedge clk); #1 cmd_valid = 1; cmd_mode = 0; cmd_base = 32'h8000; cmd_len = 8'd1;
    for (int t = 0; t < 100; t++) begin @(negedge clk); if (cmd_ready) break; end
    @(posedge clk); #1 cmd_valid = 0;
    qi = {32'd2};
    feed_idx(1, 0);
    for (int t = 0; t < 200; t++) begin @(negedge clk); if (pend) break; end
    chk(pend && busy, "reached_rsp_wait", {30'd0, pend, busy}, 32'd3);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk(cmd_ready == 0, "cmd_ready_in_mid_reset", 32'(cmd_ready), '0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk_zero_outputs("abort_outputs");
    chk(cmd_ready == 1, "cmd_ready_after_abort", 32'(cmd_ready), 32'd1);
    exp_req.delete(); exp_out.delete();
    rsp_hold = 0;
    repeat (10) @(negedge clk);
    chk(done_cnt == d0, "no_done_on_abort", 32'(done_cnt - d0), '0);
    qi = {32'd4};
    run_cmd(0, 32'h9000, 1, 0, 0);

    // Randomised commands.
    for (int n = 0; n < 40; n++) begin
      bit m; int len;
      m = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      qi.delete(); qd.delete();
      for (int k = 0; k < len; k++) begin
        qi.push_back(($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1100));
        qd.push_back($urandom);
      end
      run_cmd(m, $urandom, len, 2, int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
